// File: rtl/motoro3_pwm_pkg.sv
// Shared definitions for the N-channel motor PWM generator: mode encoding,
// default widths and the saturating adder used for remainder carry.
package motoro3_pwm_pkg;

  localparam int unsigned DEF_CNT_W = 12;
  localparam int unsigned DEF_POS_W = 16;

  typedef enum logic [1:0] {
    MODE_DIRECT     = 2'd0,
    MODE_CARRY      = 2'd1,
    MODE_FLUSH      = 2'd2,
    MODE_DIRECT_ALT = 2'd3
  } pwm_mode_t;

  // a + b clamped to the largest w-bit value (w <= 32)
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (sum > lim) ? lim[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/motoro3_pwm_chan.sv
// One PWM channel: converts the per-period request into a pulse, carries the
// sub-minimum remainder, and keeps per-frame want/real accounting.
module motoro3_pwm_chan
  import motoro3_pwm_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned POS_W = DEF_POS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic             frame_first,
  input  logic             frame_last,
  input  pwm_mode_t        mode,
  input  pwm_mode_t        cur_mode,
  input  logic [CNT_W-1:0] eff_len,
  input  logic [CNT_W-1:0] min_pulse,
  input  logic [POS_W-1:0] req,
  output logic             pwm,
  output logic [POS_W-1:0] acc_want,
  output logic [POS_W-1:0] acc_real,
  output logic [POS_W-1:0] lost
);

  logic [POS_W-1:0] remain, remain_nxt, want, real_sum;
  logic [CNT_W-1:0] pcnt, pulse;
  logic [31:0]      sum, len, req_w, sum_clip, req_clip;

  always_comb begin
    req_w      = 32'(req);
    len        = 32'(eff_len);
    sum        = sat_add(32'(remain), req_w, POS_W);
    sum_clip   = (sum < len) ? sum : len;
    req_clip   = (req_w < len) ? req_w : len;
    pulse      = '0;
    remain_nxt = '0;
    case (mode)
      MODE_CARRY, MODE_FLUSH: begin
        if (sum >= 32'(min_pulse)) begin
          pulse      = CNT_W'(sum_clip);
          remain_nxt = POS_W'(sum - sum_clip);
        end else begin
          remain_nxt = POS_W'(sum);
        end
      end
      default: pulse = CNT_W'(req_clip);
    endcase
  end

  assign pwm = (pcnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remain   <= '0;
      pcnt     <= '0;
      want     <= '0;
      real_sum <= '0;
      acc_want <= '0;
      acc_real <= '0;
      lost     <= '0;
    end else begin
      if (!en) begin
        pcnt   <= '0;
        remain <= '0;
      end else if (tick) begin
        pcnt   <= pulse;
        remain <= remain_nxt;
      end else begin
        if (pcnt != '0) pcnt <= pcnt - CNT_W'(1);
        if (frame_first && cur_mode == MODE_FLUSH) remain <= '0;
      end

      // activity on the frame_last cycle itself opens the new frame
      if (frame_last) begin
        acc_want <= want;
        acc_real <= real_sum;
        lost     <= want - real_sum;
        want     <= tick ? req : '0;
        real_sum <= {{(POS_W-1){1'b0}}, pwm};
      end else begin
        if (tick) want <= want + req;
        if (pwm) real_sum <= real_sum + POS_W'(1);
      end
    end
  end

endmodule

// File: rtl/motoro3_pwm_gen_nch.sv
// N-channel motor PWM generator: one shared period down-counter feeding
// CH_NUM pulse channels between the commutation sequencer and gate drivers.
module motoro3_pwm_gen_nch
  import motoro3_pwm_pkg::*;
#(
  parameter int unsigned CH_NUM = 3,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned POS_W  = DEF_POS_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [CNT_W-1:0]        period_len,
  input  logic [CNT_W-1:0]        min_pulse,
  input  logic [1:0]              mode,
  input  logic                    frame_first,
  input  logic                    frame_last,
  input  logic [CH_NUM*POS_W-1:0] duty_req,
  output logic [CH_NUM-1:0]       pwm,
  output logic                    period_tick,
  output logic [CH_NUM*POS_W-1:0] acc_want,
  output logic [CH_NUM*POS_W-1:0] acc_real,
  output logic [CH_NUM*POS_W-1:0] lost
);

  logic [CNT_W-1:0] cnt, eff_len;
  pwm_mode_t        mode_now, mode_q;

  assign eff_len     = (period_len < CNT_W'(2)) ? CNT_W'(2) : period_len;
  assign mode_now    = pwm_mode_t'(mode);
  assign period_tick = en && (cnt == CNT_W'(1)) && !frame_first;

  // mode_q remembers the mode of the running period for frame_first flushing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      mode_q <= MODE_DIRECT;
    end else begin
      if (!en || frame_first || cnt <= CNT_W'(1)) cnt <= eff_len;
      else                                        cnt <= cnt - CNT_W'(1);
      if (period_tick) mode_q <= mode_now;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_chan
    motoro3_pwm_chan #(
      .CNT_W(CNT_W),
      .POS_W(POS_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .tick       (period_tick),
      .frame_first(frame_first),
      .frame_last (frame_last),
      .mode       (mode_now),
      .cur_mode   (mode_q),
      .eff_len    (eff_len),
      .min_pulse  (min_pulse),
      .req        (duty_req[i*POS_W +: POS_W]),
      .pwm        (pwm[i]),
      .acc_want   (acc_want[i*POS_W +: POS_W]),
      .acc_real   (acc_real[i*POS_W +: POS_W]),
      .lost       (lost[i*POS_W +: POS_W])
    );
  end

endmodule
